// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with match/free/oldest-steal policy
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

module voice_allocator #(
  parameter int N_VOICES = `N_OSCILLATORS,
  parameter int AGE_W    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [6:0]                  ev_note,
  input  logic [7:0]                  ev_velocity,
  output logic                        voice_we,
  output logic [$clog2(N_VOICES)-1:0] voice_idx,
  output logic [6:0]                  voice_note,
  output logic [7:0]                  voice_velocity,
  output logic                        voice_gate,
  output logic                        stolen,
  output logic [N_VOICES-1:0]         active_mask
);

  localparam int IW = $clog2(N_VOICES);
  localparam logic [IW-1:0] LAST = IW'(N_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t state, state_next;

  logic [IW-1:0]    cnt;
  logic             lat_on;
  logic [6:0]       lat_note;
  logic [7:0]       lat_vel;

  logic [N_VOICES-1:0] active;
  logic [6:0]          note_tab [N_VOICES];
  logic [AGE_W-1:0]    age      [N_VOICES];

  // Running scan results: match, free and oldest candidates
  logic             m_hit, f_hit, o_hit;
  logic [IW-1:0]    m_idx, f_idx, o_idx;
  logic [AGE_W-1:0] o_age;
  logic             m_hit_n, f_hit_n, o_hit_n;
  logic [IW-1:0]    m_idx_n, f_idx_n, o_idx_n;
  logic [AGE_W-1:0] o_age_n;

  // Resolved target, frozen for the WRITE cycle
  logic             t_hit, t_steal;
  logic [IW-1:0]    t_idx;
  logic             d_hit, d_steal;
  logic [IW-1:0]    d_idx;

  assign active_mask = active;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_next = state;
    ev_ready   = 1'b0;
    voice_we   = 1'b0;
    stolen     = 1'b0;
    case (state)
      IDLE: begin
        ev_ready = rstn;
        if (ev_valid) state_next = SCAN;
      end
      SCAN: begin
        if (cnt == LAST) state_next = WRITE;
      end
      WRITE: begin
        voice_we   = t_hit;
        stolen     = t_steal;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fold the voice under inspection into the candidate trackers
  always_comb begin
    m_hit_n = m_hit;
    m_idx_n = m_idx;
    f_hit_n = f_hit;
    f_idx_n = f_idx;
    o_hit_n = o_hit;
    o_idx_n = o_idx;
    o_age_n = o_age;
    if (active[cnt] && note_tab[cnt] == lat_note && !m_hit) begin
      m_hit_n = 1'b1;
      m_idx_n = cnt;
    end
    if (!active[cnt] && !f_hit) begin
      f_hit_n = 1'b1;
      f_idx_n = cnt;
    end
    // strict compare keeps the lowest index on age ties
    if (active[cnt] && (!o_hit || age[cnt] > o_age)) begin
      o_hit_n = 1'b1;
      o_idx_n = cnt;
      o_age_n = age[cnt];
    end
  end

  // Target choice: note-on prefers match, then free, then steals oldest
  always_comb begin
    d_hit   = 1'b0;
    d_steal = 1'b0;
    d_idx   = '0;
    if (lat_on) begin
      if (m_hit_n) begin
        d_hit = 1'b1;
        d_idx = m_idx_n;
      end else if (f_hit_n) begin
        d_hit = 1'b1;
        d_idx = f_idx_n;
      end else begin
        d_hit   = o_hit_n;
        d_steal = o_hit_n;
        d_idx   = o_idx_n;
      end
    end else begin
      d_hit = m_hit_n;
      d_idx = m_idx_n;
    end
  end

  // Event latch, scan bookkeeping, voice table and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt            <= '0;
      lat_on         <= 1'b0;
      lat_note       <= '0;
      lat_vel        <= '0;
      active         <= '0;
      m_hit          <= 1'b0;
      f_hit          <= 1'b0;
      o_hit          <= 1'b0;
      m_idx          <= '0;
      f_idx          <= '0;
      o_idx          <= '0;
      o_age          <= '0;
      t_hit          <= 1'b0;
      t_steal        <= 1'b0;
      t_idx          <= '0;
      voice_idx      <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_gate     <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        age[i]      <= '0;
        note_tab[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ev_valid) begin
            lat_on   <= ev_on && (ev_velocity != 8'd0);
            lat_note <= ev_note;
            lat_vel  <= ev_velocity;
            cnt      <= '0;
            m_hit    <= 1'b0;
            f_hit    <= 1'b0;
            o_hit    <= 1'b0;
          end
        end
        SCAN: begin
          cnt   <= cnt + 1'b1;
          m_hit <= m_hit_n;
          m_idx <= m_idx_n;
          f_hit <= f_hit_n;
          f_idx <= f_idx_n;
          o_hit <= o_hit_n;
          o_idx <= o_idx_n;
          o_age <= o_age_n;
          if (cnt == LAST) begin
            t_hit   <= d_hit;
            t_steal <= d_steal;
            t_idx   <= d_idx;
            if (d_hit) begin
              voice_idx      <= d_idx;
              voice_note     <= lat_on ? lat_note : note_tab[d_idx];
              voice_velocity <= lat_on ? lat_vel : 8'd0;
              voice_gate     <= lat_on;
            end
          end
        end
        WRITE: begin
          if (t_hit) begin
            if (lat_on) begin
              active[t_idx]   <= 1'b1;
              note_tab[t_idx] <= lat_note;
              for (int i = 0; i < N_VOICES; i++) begin
                if (IW'(i) == t_idx)
                  age[i] <= '0;
                else if (active[i] && age[i] != AGE_MAX)
                  age[i] <= age[i] + 1'b1;
              end
            end else begin
              active[t_idx] <= 1'b0;
            end
          end
          t_hit   <= 1'b0;
          t_steal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
module tb_voice_allocator;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic [7:0] ev_velocity = '0;
  logic       ev_ready;
  logic       voice_we;
  logic [2:0] voice_idx;
  logic [6:0] voice_note;
  logic [7:0] voice_velocity;
  logic       voice_gate;
  logic       stolen;
  logic [7:0] active_mask;

  int total = 0;
  int bad = 0;

  voice_allocator #(.N_VOICES(N), .AGE_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_velocity(ev_velocity),
    .voice_we(voice_we), .voice_idx(voice_idx), .voice_note(voice_note),
    .voice_velocity(voice_velocity), .voice_gate(voice_gate),
    .stolen(stolen), .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] n_we;
    logic [2:0] idx;
    logic [6:0] note;
    logic [7:0] vel;
    logic       gate;
    logic       stl;
    logic [7:0] mask;
    logic [4:0] lat;
    logic [4:0] rdy;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  // reference model of the voice table
  bit       m_act [N];
  int       m_note[N];
  int       m_age [N];
  int       h_idx, h_note, h_vel, h_gate;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
    h_idx = 0; h_note = 0; h_vel = 0; h_gate = 0;
  endtask

  task automatic model_push(input logic on, input logic [6:0] note, input logic [7:0] vel);
    rec_t e;
    int   t = -1;
    bit   st = 0;
    bit   is_on = on && (vel != 0);
    for (int i = 0; i < N; i++)
      if (t < 0 && m_act[i] && m_note[i] == int'(note)) t = i;
    if (is_on && t < 0)
      for (int i = 0; i < N; i++)
        if (t < 0 && !m_act[i]) t = i;
    if (is_on && t < 0) begin
      t = 0;
      for (int i = 1; i < N; i++)
        if (m_age[i] > m_age[t]) t = i;
      st = 1;
    end
    if (t >= 0) begin
      h_idx = t;
      if (is_on) begin
        h_note = int'(note); h_vel = int'(vel); h_gate = 1;
        for (int i = 0; i < N; i++)
          if (i != t && m_act[i] && m_age[i] < 255) m_age[i]++;
        m_age[t] = 0; m_act[t] = 1; m_note[t] = int'(note);
      end else begin
        h_note = m_note[t]; h_vel = 0; h_gate = 0;
        m_act[t] = 0;
      end
    end
    e.n_we = (t >= 0) ? 4'd1 : 4'd0;
    e.idx  = 3'(h_idx);
    e.note = 7'(h_note);
    e.vel  = 8'(h_vel);
    e.gate = h_gate[0];
    e.stl  = st;
    for (int i = 0; i < N; i++) e.mask[i] = m_act[i];
    e.lat  = (t >= 0) ? 5'd9 : 5'd0;
    e.rdy  = 5'd10;
    exp_q.push_back(e);
  endtask

  // drive one event, scribble on ev_* while busy, record what the DUT did
  task automatic do_event(input logic on, input logic [6:0] note, input logic [7:0] vel);
    rec_t o;
    int   w = 0;
    model_push(on, note, vel);
    @(negedge clk);
    while (!ev_ready && w < 50) begin @(negedge clk); w++; end
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_velocity = vel;
    @(posedge clk); #1;
    ev_on = 1'($urandom); ev_note = 7'($urandom); ev_velocity = 8'($urandom);
    o = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 8) ev_valid = 1'b0;
      if (stolen) o.stl = 1'b1;
      if (voice_we) begin
        o.n_we = o.n_we + 4'd1;
        o.lat  = 5'(c);
        o.idx = voice_idx; o.note = voice_note; o.vel = voice_velocity; o.gate = voice_gate;
      end
      if (ev_ready) begin
        o.rdy  = 5'(c);
        o.mask = active_mask;
        if (o.n_we == 0) begin
          o.idx = voice_idx; o.note = voice_note; o.vel = voice_velocity; o.gate = voice_gate;
        end
        break;
      end
    end
    ev_valid = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic apply_reset();
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk); rstn = 1'b0; ev_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({ev_ready, voice_we, stolen, voice_idx, voice_note, voice_velocity, voice_gate, active_mask} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b st=%b idx=%0d note=%0d vel=%0d gate=%b mask=%h, want all 0",
               ev_ready, voice_we, stolen, voice_idx, voice_note, voice_velocity, voice_gate, active_mask);
    end
    ev_valid = 1'b0; rstn = 1'b1;
    model_clear();
    @(posedge clk); #1;
    total++;
    if (ev_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", ev_ready);
    end
  endtask

  task automatic test_latency();
    rec_t e, o;
    apply_reset();
    do_event(1'b1, 7'd33, 8'd100);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL latency_note_on: got=%h want=%h", o, e); end
  endtask

  task automatic test_steal();
    rec_t e, o;
    apply_reset();
    for (int k = 0; k < 9; k++) do_event(1'b1, (k < 8) ? 7'(20 + k) : 7'd40, 8'(10 + k));
    for (int k = 0; k < 9; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL steal_ev%0d: got=%h want=%h", k, o, e); end
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.age[i] !== 8'(m_age[i])) begin
        bad++; $display("FAIL steal_age%0d: got %0d want %0d", i, dut.age[i], m_age[i]);
      end
    end
  endtask

  task automatic test_retrigger_release();
    rec_t e, o;
    apply_reset();
    do_event(1'b1, 7'd30, 8'd90);
    do_event(1'b1, 7'd31, 8'd80);
    do_event(1'b1, 7'd30, 8'd70);
    do_event(1'b0, 7'd31, 8'd55);
    do_event(1'b0, 7'd31, 8'd55);
    do_event(1'b1, 7'd30, 8'd0);
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL retrig_release_ev%0d: got=%h want=%h", k, o, e); end
    end
  endtask

  task automatic test_abort();
    rec_t e, o;
    int   n_we = 0;
    apply_reset();
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_velocity = 8'd64;
    @(posedge clk); #1 ev_valid = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if (ev_ready !== 1'b0 || voice_we !== 1'b0) begin
      bad++; $display("FAIL abort_in_reset: got rdy=%b we=%b want 0 0", ev_ready, voice_we);
    end
    rstn = 1'b1;
    model_clear();
    @(negedge clk);
    total++;
    if (ev_ready !== 1'b1 || active_mask !== 8'h00) begin
      bad++; $display("FAIL abort_release: got rdy=%b mask=%h want 1 00", ev_ready, active_mask);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (voice_we) n_we++;
    end
    total++;
    if (n_we != 0) begin bad++; $display("FAIL abort_no_write: got %0d strobes want 0", n_we); end
    do_event(1'b1, 7'd61, 8'd70);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL abort_next_event: got=%h want=%h", o, e); end
  endtask

  task automatic test_age_saturation();
    rec_t e, o;
    int   errs = 0;
    apply_reset();
    do_event(1'b1, 7'd10, 8'd1);
    for (int k = 0; k < 260; k++) do_event(1'b1, 7'd11, 8'd2);
    for (int k = 0; k < 261; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e && errs < 3) $display("FAIL saturate_ev%0d: got=%h want=%h", k, o, e);
      if (o !== e) errs++;
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (dut.age[0] !== 8'(m_age[0]) || dut.age[1] !== 8'(m_age[1])) begin
      bad++; $display("FAIL saturate_ages: got %0d/%0d want %0d/%0d", dut.age[0], dut.age[1], m_age[0], m_age[1]);
    end
    do_event(1'b1, 7'd12, 8'd3);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL saturate_free_after: got=%h want=%h", o, e); end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_latency();
    test_steal();
    test_retrigger_release();
    test_abort();
    test_age_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
